// File: rtl/sync_fifo_gen2.sv
// Single-clock FIFO with occupancy and threshold flags and one-cycle error pulses.
// The FWFT parameter selects the read mode. With FWFT=0 the read data is registered.
// With FWFT=1 the head word is visible on the output without a read.
module sync_fifo_gen2 #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2,
    parameter int unsigned FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         fifo_data_in,
    input  logic                     fifo_write,
    input  logic                     fifo_read,
    output logic [WIDTH-1:0]         fifo_data_out,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     fifo_almost_full,
    output logic                     fifo_almost_empty,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_overflow,
    output logic                     fifo_underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt  = CW'(DEPTH);
    localparam logic [CW-1:0] AfullTh  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AemptyTh = CW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             full, empty, rd_acc, wr_acc;

    // Accept decisions, pointer/count next state and error pulse next state.
    always_comb begin
        full     = (count_q == FullCnt);
        empty    = (count_q == '0);
        rd_acc   = fifo_read && !empty;
        // A read on the same edge frees a slot, so a full FIFO still takes the write.
        wr_acc   = fifo_write && (!full || rd_acc);
        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = fifo_write && full && !rd_acc;
        unf_d = fifo_read && empty;
    end

    // State registers; reset wins over any simultaneous request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage write; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= fifo_data_in;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word drives the output directly; meaningless while empty.
        assign fifo_data_out = mem_q[rd_ptr_q];
    end else begin : g_reg
        logic [WIDTH-1:0] dout_q;

        // Registered read data: loads on an accepted read, holds otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem_q[rd_ptr_q];
            end
        end

        assign fifo_data_out = dout_q;
    end

    assign fifo_full         = full;
    assign fifo_empty        = empty;
    assign fifo_almost_full  = (count_q >= AfullTh);
    assign fifo_almost_empty = (count_q <= AemptyTh);
    assign fifo_count        = count_q;
    assign fifo_overflow     = ovf_q;
    assign fifo_underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_gen2.sv
// Bench for sync_fifo_gen2. It runs one registered-read instance and one FWFT instance
// side by side on the same stimulus. Both are checked against a queue-based model.
module tb_sync_fifo_gen2;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 16;
    localparam int unsigned AF = 14;
    localparam int unsigned AE = 2;
    localparam int unsigned CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst, wr, rd;
    logic [W-1:0]  din;

    logic [W-1:0]  dout0, dout1;
    logic          full0, empty0, af0, ae0, ovf0, unf0;
    logic          full1, empty1, af1, ae1, ovf1, unf1;
    logic [CW-1:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] q[$];
    logic [W-1:0] exp_dout0;
    logic         exp_ovf, exp_unf;

    always #5 clk = ~clk;

    sync_fifo_gen2 #(
        .WIDTH(W), .DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)
    ) u_reg (
        .clk(clk), .rst(rst), .fifo_data_in(din), .fifo_write(wr), .fifo_read(rd),
        .fifo_data_out(dout0), .fifo_full(full0), .fifo_empty(empty0),
        .fifo_almost_full(af0), .fifo_almost_empty(ae0), .fifo_count(cnt0),
        .fifo_overflow(ovf0), .fifo_underflow(unf0)
    );

    sync_fifo_gen2 #(
        .WIDTH(W), .DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)
    ) u_fwft (
        .clk(clk), .rst(rst), .fifo_data_in(din), .fifo_write(wr), .fifo_read(rd),
        .fifo_data_out(dout1), .fifo_full(full1), .fifo_empty(empty1),
        .fifo_almost_full(af1), .fifo_almost_empty(ae1), .fifo_count(cnt1),
        .fifo_overflow(ovf1), .fifo_underflow(unf1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare 1 ns later.
    task automatic step(input logic r, input logic w, input logic rdn, input logic [W-1:0] d);
        bit rd_ok, wr_ok;
        int n;
        rst = r; wr = w; rd = rdn; din = d;
        @(posedge clk);
        if (r) begin
            q.delete();
            exp_dout0 = '0;
            exp_ovf   = 1'b0;
            exp_unf   = 1'b0;
        end else begin
            n       = q.size();
            rd_ok   = rdn && (n > 0);
            wr_ok   = w && ((n < int'(D)) || rd_ok);
            exp_ovf = w && (n == int'(D)) && !rd_ok;
            exp_unf = rdn && (n == 0);
            if (rd_ok) exp_dout0 = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
        #1;
        n = q.size();
        check("count",      64'(cnt0),   64'(n));
        check("full",       64'(full0),  64'(n == int'(D)));
        check("empty",      64'(empty0), 64'(n == 0));
        check("almost_full",  64'(af0),  64'(n >= int'(AF)));
        check("almost_empty", 64'(ae0),  64'(n <= int'(AE)));
        check("overflow",   64'(ovf0),   64'(exp_ovf));
        check("underflow",  64'(unf0),   64'(exp_unf));
        check("dout_reg",   64'(dout0),  64'(exp_dout0));
        check("fwft_count", 64'(cnt1),   64'(n));
        check("fwft_empty", 64'(empty1), 64'(n == 0));
        check("fwft_ovf",   64'(ovf1),   64'(exp_ovf));
        check("fwft_unf",   64'(unf1),   64'(exp_unf));
        if (n > 0) check("dout_fwft", 64'(dout1), 64'(q[0]));
    endtask

    initial begin
        int wbias;
        rst = 1'b1; wr = 1'b0; rd = 1'b0; din = '0;
        exp_dout0 = '0; exp_ovf = 1'b0; exp_unf = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 16'hFFFF);
        check("rst_af", 64'(af0), 64'(0));
        check("rst_ae", 64'(ae0), 64'(1));
        check("rst_dout", 64'(dout0), 64'(0));

        // Fill 1..16, then one rejected write
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 1'b0, W'(i));
            if (i == 13) check("af_before_14", 64'(af0), 64'(0));
            if (i == 14) check("af_after_14", 64'(af0), 64'(1));
            if (i == 15) check("full_before_16", 64'(full0), 64'(0));
        end
        check("full_after_16", 64'(full0), 64'(1));
        step(1'b0, 1'b1, 1'b0, 16'h0011);
        check("ovf_pulse", 64'(ovf0), 64'(1));
        step(1'b0, 1'b0, 1'b0, '0);
        check("ovf_one_cycle", 64'(ovf0), 64'(0));

        // Drain 16 with registered read data, then one underflowing read
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            check("drain_order", 64'(dout0), 64'(i));
        end
        step(1'b0, 1'b0, 1'b1, '0);
        check("unf_hold_dout", 64'(dout0), 64'(16));
        check("unf_pulse", 64'(unf0), 64'(1));

        // Full with simultaneous read and write across pointer wrap
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, W'(16'h0100 + i));
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, W'(16'h0200 + i));
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, '0);

        // Empty with simultaneous read and write
        step(1'b0, 1'b1, 1'b1, 16'h00AA);
        check("empty_rw_unf", 64'(unf0), 64'(1));
        check("empty_rw_fwft", 64'(dout1), 64'(16'h00AA));
        step(1'b0, 1'b0, 1'b1, '0);

        // Reset mid-operation discards stored words
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, W'(16'h0500 + i));
        step(1'b1, 1'b1, 1'b0, 16'hDEAD);
        check("mid_rst_empty", 64'(empty0), 64'(1));
        step(1'b0, 1'b1, 1'b0, 16'h1234);
        check("post_rst_fwft", 64'(dout1), 64'(16'h1234));
        step(1'b0, 1'b0, 1'b1, '0);
        check("post_rst_read", 64'(dout0), 64'(16'h1234));

        // Randomized traffic with alternating bias to visit full and empty regions
        for (int i = 0; i < 600; i++) begin
            wbias = ((i / 60) % 2 == 0) ? 75 : 25;
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < wbias),
                 ($urandom_range(0, 99) < (100 - wbias)),
                 W'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_gen2.md
SYNC_FIFO_GEN2 -- requirements
Module: sync_fifo_gen2

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data word width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 16, entry count, a power of two, 2..1024.
REQ-003 The block SHALL have parameter AFULL_TH, default DEPTH-2, almost-full threshold (1..DEPTH).
REQ-004 The block SHALL have parameter AEMPTY_TH, default 2, almost-empty threshold (0..DEPTH-1).
REQ-005 The block SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port fifo_data_in, input, WIDTH, write data.
REQ-009 The block SHALL have port fifo_write, input, 1, write request.
REQ-010 The block SHALL have port fifo_read, input, 1, read request.
REQ-011 The block SHALL have port fifo_data_out, output, WIDTH, read data.
REQ-012 The block SHALL have ports fifo_full and fifo_empty, output, 1 each, occupancy status.
REQ-013 The block SHALL have ports fifo_almost_full and fifo_almost_empty, output, 1 each, threshold status.
REQ-014 The block SHALL have port fifo_count, output, $clog2(DEPTH)+1, current occupancy 0..DEPTH.
REQ-015 The block SHALL have ports fifo_overflow and fifo_underflow, output, 1 each, one-cycle error pulses.

Function
REQ-016 Storage: DEPTH x WIDTH array; write pointer and read pointer, $clog2(DEPTH) bits each, wrap from DEPTH-1 to 0 with no gap.
REQ-017 Write accepted = fifo_write && (!fifo_full || read accepted); accepted write stores fifo_data_in at wr_ptr and advances wr_ptr.
REQ-018 Read accepted = fifo_read && !fifo_empty; an accepted read advances rd_ptr.
REQ-019 fifo_count: +1 on write-only, -1 on read-only, unchanged when both or neither are accepted.
REQ-020 Full with simultaneous read and write: both accepted, count stays DEPTH, fifo_overflow not asserted.
REQ-021 Empty with simultaneous read and write: write accepted, read rejected, count becomes 1, fifo_underflow pulses.
REQ-022 fifo_full = (count==DEPTH); fifo_empty = (count==0); both are decoded from the registered count and change on the same edge as count.
REQ-023 fifo_almost_full = (count >= AFULL_TH); fifo_almost_empty = (count <= AEMPTY_TH); both are decoded from the registered count.
REQ-024 fifo_overflow is high for exactly the cycle after a rejected write (fifo_write && fifo_full && !read accepted); memory and pointers are unchanged.
REQ-025 fifo_underflow is high for exactly the cycle after a rejected read (fifo_read && fifo_empty); data_out and pointers are unchanged.
REQ-026 FWFT=0: fifo_data_out registered; it loads mem[rd_ptr] on the edge accepting the read (1-cycle latency) and holds its value otherwise.
REQ-027 FWFT=1: fifo_data_out = mem[rd_ptr] whenever !fifo_empty, i.e. the head word is visible without a read; an accepted read pops it, and the next word is visible the following cycle.
REQ-028 FWFT=1: a word written into an empty FIFO appears on fifo_data_out one cycle after the write edge; fifo_data_out is don't-care while empty.
REQ-029 Write data is never bypassed to the output in the same cycle in either mode.

Reset
REQ-030 When rst is high at a rising edge, the block SHALL set pointers=0, count=0, fifo_empty=1, fifo_full=0, fifo_almost_empty=1, fifo_almost_full=0, fifo_overflow=0, fifo_underflow=0, and (FWFT=0) fifo_data_out=0.
REQ-031 Reset SHALL take priority over simultaneous fifo_write/fifo_read, discarding those requests; memory contents are not cleared.
REQ-032 Reset asserted mid-operation SHALL discard all stored words: after release the FIFO is empty and the first read returns the first post-reset write.

Verification (WIDTH=16, DEPTH=16, AFULL_TH=14, AEMPTY_TH=2)
REQ-033 Write 1..16 with no reads -> count reaches 16, fifo_almost_full rises after the 14th write, fifo_full after the 16th; a 17th write pulses fifo_overflow for 1 cycle, count stays 16.
REQ-034 FWFT=0: read 16 words -> outputs 1..16 in order, each one cycle after its read; fifo_empty after the last read; one more read pulses fifo_underflow, data_out holds 16.
REQ-035 Full FIFO, fifo_write=fifo_read=1 for 20 cycles with incrementing data -> count stays 16, no overflow, order preserved across pointer wrap.
REQ-036 Empty FIFO, write 0x00AA with a read in the same cycle -> underflow pulse, count=1; FWFT=1: data_out=0x00AA on the next cycle, fifo_empty=0.
REQ-037 Write 5 words, assert rst for one cycle together with fifo_write=1 -> count=0, fifo_empty=1, all flags in reset state; next write 0x1234 then read returns 0x1234.
